// File: rtl/bcd_pkg.sv
// Shared constants, FSM encoding and digit helpers for the sequential BCD adder.
package bcd_pkg;

    localparam int unsigned BCD_DIGIT_W = 4;
    localparam int unsigned BCD_MAX     = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Nines complement of one BCD digit (9 - d), used for subtraction.
    function automatic logic [BCD_DIGIT_W-1:0] nines_comp(input logic [BCD_DIGIT_W-1:0] d);
        return BCD_DIGIT_W'(BCD_MAX) - d;
    endfunction

endpackage

// File: rtl/bcd_adder.sv
// Single-digit combinational BCD adder with decimal correction and range flag.
module bcd_adder
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] X,
    input  logic [BCD_DIGIT_W-1:0] Y,
    input  logic                   c_in,
    output logic [BCD_DIGIT_W-1:0] result,
    output logic                   c_out,
    output logic                   out_of_range
);

    logic [BCD_DIGIT_W:0] bin_sum;

    // Binary sum, then +6 correction whenever the digit exceeds 9.
    always_comb begin
        bin_sum      = (BCD_DIGIT_W+1)'(X) + (BCD_DIGIT_W+1)'(Y) + (BCD_DIGIT_W+1)'(c_in);
        c_out        = (bin_sum > (BCD_DIGIT_W+1)'(BCD_MAX));
        result       = c_out ? BCD_DIGIT_W'(bin_sum + (BCD_DIGIT_W+1)'(6)) : bin_sum[BCD_DIGIT_W-1:0];
        out_of_range = (X > BCD_DIGIT_W'(BCD_MAX)) | (Y > BCD_DIGIT_W'(BCD_MAX));
    end

endmodule

// File: rtl/bcd_seq_adder.sv
// N-digit packed-BCD adder, one digit per clock through a single bcd_adder.
// Optional subtract mode (nines complement) enabled by defining BCD_SUB_EN.
module bcd_seq_adder
    import bcd_pkg::*;
#(
    parameter int unsigned NDIGITS = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [BCD_DIGIT_W*NDIGITS-1:0] a,
    input  logic [BCD_DIGIT_W*NDIGITS-1:0] b,
    input  logic                           cin,
`ifdef BCD_SUB_EN
    input  logic                           sub,
`endif
    output logic                           busy,
    output logic                           done,
    output logic [BCD_DIGIT_W*NDIGITS-1:0] sum,
    output logic                           cout,
    output logic                           error
);

    localparam int unsigned W     = BCD_DIGIT_W * NDIGITS;
    localparam int unsigned CNT_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    state_e                 state_q, state_d;
    logic [W-1:0]           a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   carry_q, carry_d;
    logic                   cout_q, cout_d, error_q, error_d;
    logic                   busy_q, busy_d, done_q, done_d;

    logic [BCD_DIGIT_W-1:0] dig_a, dig_b, add_y, add_res;
    logic                   add_cout, add_oor, b_err;

    assign dig_a = a_q[BCD_DIGIT_W-1:0];
    assign dig_b = b_q[BCD_DIGIT_W-1:0];

`ifdef BCD_SUB_EN
    logic sub_q, sub_d;

    // Range check uses the raw b digit, before complementing.
    assign add_y = sub_q ? nines_comp(dig_b) : dig_b;
    assign b_err = sub_q & (dig_b > BCD_DIGIT_W'(BCD_MAX));
`else
    assign add_y = dig_b;
    assign b_err = 1'b0;
`endif

    bcd_adder u_bcd_adder (
        .X            (dig_a),
        .Y            (add_y),
        .c_in         (carry_q),
        .result       (add_res),
        .c_out        (add_cout),
        .out_of_range (add_oor)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        error_d = error_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef BCD_SUB_EN
        sub_d   = sub_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
`ifdef BCD_SUB_EN
                    sub_d   = sub;
                    if (sub) carry_d = 1'b1;
`endif
                end
            end
            RUN: begin
                // Consume the low digit; result enters sum at the MS end.
                a_d     = a_q >> BCD_DIGIT_W;
                b_d     = b_q >> BCD_DIGIT_W;
                sum_d   = (sum_q >> BCD_DIGIT_W) | (W'(add_res) << (W - BCD_DIGIT_W));
                carry_d = add_cout;
                error_d = error_q | add_oor | b_err;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(NDIGITS - 1)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cout_d  = add_cout;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            error_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef BCD_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            error_q <= error_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef BCD_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign cout  = cout_q;
    assign error = error_q;

endmodule

// File: tb/tb_bcd_seq_adder.sv
// Directed bench for bcd_seq_adder (NDIGITS=4); subtract vectors run when BCD_SUB_EN is defined.
module tb_bcd_seq_adder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        sub_v = 1'b0;
    logic        busy, done, cout, error;
    logic [15:0] sum;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bcd_seq_adder #(.NDIGITS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef BCD_SUB_EN
        .sub   (sub_v),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .error (error)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        err;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Launch one operation and wait (bounded) for done; leaves at the negedge where done is high.
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tcin,
                         input logic tsub, output int lat, output int busy_cnt);
        @(negedge clk);
        a = ta; b = tb_v; cin = tcin; sub_v = tsub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, bcnt, t, d1, d2, seen;

        vecs[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0};
        vecs[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0};
        vecs[3] = '{16'h12A4, 16'h0001, 1'b0, 16'h1305, 1'b0, 1'b1};
        vecs[4] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[6] = '{16'h4567, 16'h5433, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{16'h0999, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[8] = '{16'h5000, 16'h5000, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[9] = '{16'h0F00, 16'h0000, 1'b0, 16'h1500, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_busy",  32'(busy),  32'd0);
        check("reset_done",  32'(done),  32'd0);
        check("reset_sum",   32'(sum),   32'd0);
        check("reset_cout",  32'(cout),  32'd0);
        check("reset_error", 32'(error), 32'd0);

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, lat, bcnt);
            check($sformatf("v%0d_latency", i), 32'(lat),   32'd4);
            check($sformatf("v%0d_busycnt", i), 32'(bcnt),  32'd4);
            check($sformatf("v%0d_sum", i),     32'(sum),   32'(vecs[i].sum));
            check($sformatf("v%0d_cout", i),    32'(cout),  32'(vecs[i].cout));
            check($sformatf("v%0d_error", i),   32'(error), 32'(vecs[i].err));
        end

        // Start held high: operations back to back every 5 cycles.
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
        t = 0; d1 = -1; d2 = -1;
        while (d2 < 0 && t < 30) begin
            @(negedge clk);
            t++;
            if (done) begin
                if (d1 < 0) d1 = t;
                else d2 = t;
            end
        end
        start = 1'b0;
        check("held_first_done",  32'(d1),  32'd5);
        check("held_second_done", 32'(d2),  32'd10);
        check("held_sum",         32'(sum), 32'h3333);

        // Start pulses and operand changes while busy must be ignored.
        @(negedge clk);
        a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 16'h9999; b = 16'h9999; cin = 1'b1;
        lat = 0;
        while (!done && lat < 20) begin
            start = (lat == 1 || lat == 2);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("ignore_latency", 32'(lat),  32'd4);
        check("ignore_sum",     32'(sum),  32'h6912);
        check("ignore_cout",    32'(cout), 32'd0);
        @(negedge clk);
        check("ignore_no_restart", 32'(busy), 32'd0);

        // Reset two cycles into RUN aborts without a done pulse.
        do_op(16'h9999, 16'h0001, 1'b0, 1'b0, lat, bcnt);
        check("prereset_cout", 32'(cout), 32'd1);
        @(negedge clk);
        a = 16'h12A4; b = 16'h0001; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("prereset_error", 32'(error), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy",  32'(busy),  32'd0);
        check("abort_done",  32'(done),  32'd0);
        check("abort_sum",   32'(sum),   32'd0);
        check("abort_cout",  32'(cout),  32'd0);
        check("abort_error", 32'(error), 32'd0);
        reset = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        do_op(16'h0001, 16'h0001, 1'b0, 1'b0, lat, bcnt);
        check("post_abort_latency", 32'(lat), 32'd4);
        check("post_abort_sum",     32'(sum), 32'h0002);

`ifdef BCD_SUB_EN
        do_op(16'h0500, 16'h0123, 1'b0, 1'b1, lat, bcnt);
        check("sub1_latency", 32'(lat),   32'd4);
        check("sub1_sum",     32'(sum),   32'h0377);
        check("sub1_cout",    32'(cout),  32'd1);
        check("sub1_error",   32'(error), 32'd0);
        do_op(16'h0100, 16'h0200, 1'b0, 1'b1, lat, bcnt);
        check("sub2_sum",     32'(sum),   32'h9900);
        check("sub2_cout",    32'(cout),  32'd0);
        do_op(16'h1234, 16'h5678, 1'b0, 1'b0, lat, bcnt);
        check("sub0_add_sum", 32'(sum),   32'h6912);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
